// File: rtl/mm_pkg.sv
// mm_pkg: shared state encoding, width helpers and peg-field access for the mastermind engine.
package mm_pkg;

    typedef enum logic [1:0] {IDLE, EDIT, SCORE, DONE} state_e;

    function automatic int cw(input int n_colors);
        return $clog2(n_colors);
    endfunction

    function automatic int pw(input int n_pegs);
        return $clog2(n_pegs);
    endfunction

    function automatic int cntw(input int n_pegs);
        return $clog2(n_pegs + 1);
    endfunction

    // Codes are at most 8 pegs x 4 bits, so a 32-bit container covers every legal configuration.
    function automatic logic [3:0] peg_get(input logic [31:0] v, input int i, input int w);
        logic [31:0] s;
        s = v >> (i * w);
        return 4'(s & ((32'd1 << w) - 32'd1));
    endfunction

endpackage

// File: rtl/mm_scorer.sv
// mm_scorer: multi-cycle black/white scorer; one cycle for exact matches, then one cycle per colour.
module mm_scorer import mm_pkg::*; #(
    parameter int N_PEGS = 4,
    parameter int N_COLORS = 8,
    localparam int CW = cw(N_COLORS),
    localparam int CNTW = cntw(N_PEGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   start,
    input  logic [N_PEGS*CW-1:0]   secret,
    input  logic [N_PEGS*CW-1:0]   guess,
    output logic                   done,
    output logic [CNTW-1:0]        black,
    output logic [CNTW-1:0]        white
);

    logic            active_q, first_q;
    logic [CW-1:0]   c_q;
    logic [CNTW-1:0] acc_q, black_q, exact, n_s, n_g, m;

    always_comb begin
        exact = '0;
        n_s = '0;
        n_g = '0;
        for (int i = 0; i < N_PEGS; i++) begin
            exact = exact + CNTW'(peg_get(32'(secret), i, CW) == peg_get(32'(guess), i, CW));
            n_s = n_s + CNTW'(peg_get(32'(secret), i, CW) == 4'(c_q));
            n_g = n_g + CNTW'(peg_get(32'(guess), i, CW) == 4'(c_q));
        end
        m = (n_s < n_g) ? n_s : n_g;
    end

    // The last colour's contribution is folded in combinationally so results appear with done.
    assign done  = active_q & ~first_q & (c_q == CW'(N_COLORS - 1));
    assign black = black_q;
    assign white = acc_q + m - black_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            active_q <= 1'b0;
            first_q  <= 1'b0;
            c_q      <= '0;
            acc_q    <= '0;
            black_q  <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            first_q  <= 1'b1;
        end else if (active_q) begin
            if (first_q) begin
                black_q <= exact;
                c_q     <= '0;
                acc_q   <= '0;
                first_q <= 1'b0;
            end else begin
                acc_q <= acc_q + m;
                c_q   <= c_q + 1'b1;
                if (done)
                    active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mastermind_core.sv
// mastermind_core: game FSM holding the secret, editing the guess from button pulses,
// scoring submissions and tracking turns, win and loss.
module mastermind_core import mm_pkg::*; #(
    parameter int N_PEGS = 4,
    parameter int N_COLORS = 8,
    parameter int MAX_TURNS = 8,
    localparam int CW = cw(N_COLORS),
    localparam int PW = pw(N_PEGS),
    localparam int CNTW = cntw(N_PEGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 secret_load,
    input  logic [N_PEGS*CW-1:0] secret_in,
    input  logic                 btn_l,
    input  logic                 btn_r,
    input  logic                 btn_u,
    input  logic                 btn_d,
    input  logic                 btn_s,
    output logic [PW-1:0]        cur_peg,
    output logic [N_PEGS*CW-1:0] guess_out,
    output logic [CNTW-1:0]      black,
    output logic [CNTW-1:0]      white,
    output logic                 score_valid,
    output logic [MAX_TURNS-1:0] turn_led,
    output logic                 busy,
    output logic                 won,
    output logic                 lost
);

    state_e               state_q;
    logic [N_PEGS*CW-1:0] secret_q, guess_q, guess_d, secret_clamp;
    logic [PW-1:0]        cur_peg_q, peg_inc, peg_dec, peg_d;
    logic [CW-1:0]        col, col_inc, col_dec, col_new;
    logic [CNTW-1:0]      black_q, white_q, sc_black, sc_white;
    logic [MAX_TURNS-1:0] turn_q;
    logic                 score_valid_q, won_q, lost_q, sc_done;

    always_comb begin
        col     = CW'(peg_get(32'(guess_q), int'(cur_peg_q), CW));
        col_inc = (col == CW'(N_COLORS - 1)) ? '0 : col + 1'b1;
        col_dec = (col == '0) ? CW'(N_COLORS - 1) : col - 1'b1;
        col_new = (btn_u & ~btn_d) ? col_inc : (btn_d & ~btn_u) ? col_dec : col;
        guess_d = guess_q;
        guess_d[int'(cur_peg_q)*CW +: CW] = col_new;
        peg_inc = (cur_peg_q == PW'(N_PEGS - 1)) ? '0 : cur_peg_q + 1'b1;
        peg_dec = (cur_peg_q == '0) ? PW'(N_PEGS - 1) : cur_peg_q - 1'b1;
        peg_d   = (btn_l & ~btn_r) ? peg_dec : (btn_r & ~btn_l) ? peg_inc : cur_peg_q;
        secret_clamp = '0;
        for (int i = 0; i < N_PEGS; i++)
            secret_clamp[i*CW +: CW] = (int'(peg_get(32'(secret_in), i, CW)) >= N_COLORS) ?
                CW'(N_COLORS - 1) : CW'(peg_get(32'(secret_in), i, CW));
    end

    mm_scorer #(.N_PEGS(N_PEGS), .N_COLORS(N_COLORS)) u_scorer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (secret_load),
        .start  (state_q == EDIT && btn_s && !secret_load),
        .secret (secret_q),
        .guess  (guess_q),
        .done   (sc_done),
        .black  (sc_black),
        .white  (sc_white)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            secret_q      <= '0;
            guess_q       <= '0;
            cur_peg_q     <= '0;
            black_q       <= '0;
            white_q       <= '0;
            score_valid_q <= 1'b0;
            turn_q        <= '0;
            won_q         <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            score_valid_q <= 1'b0;
            if (secret_load) begin
                state_q   <= EDIT;
                secret_q  <= secret_clamp;
                guess_q   <= '0;
                cur_peg_q <= '0;
                black_q   <= '0;
                white_q   <= '0;
                turn_q    <= MAX_TURNS'(1);
                won_q     <= 1'b0;
                lost_q    <= 1'b0;
            end else begin
                case (state_q)
                    EDIT: begin
                        if (btn_s) begin
                            state_q <= SCORE;
                        end else begin
                            guess_q   <= guess_d;
                            cur_peg_q <= peg_d;
                        end
                    end
                    SCORE: begin
                        if (sc_done) begin
                            black_q       <= sc_black;
                            white_q       <= sc_white;
                            score_valid_q <= 1'b1;
                            if (sc_black == CNTW'(N_PEGS)) begin
                                won_q   <= 1'b1;
                                state_q <= DONE;
                            end else if (turn_q[MAX_TURNS-1]) begin
                                lost_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                turn_q  <= turn_q << 1;
                                state_q <= EDIT;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cur_peg     = cur_peg_q;
    assign guess_out   = guess_q;
    assign black       = black_q;
    assign white       = white_q;
    assign score_valid = score_valid_q;
    assign turn_led    = turn_q;
    assign busy        = state_q == SCORE;
    assign won         = won_q;
    assign lost        = lost_q;

endmodule

// File: tb/tb_mastermind_core.sv
// tb_mastermind_core: randomized and directed game play against a counting reference model,
// with a scoreboard monitor checking every score_valid pulse.
module tb_mastermind_core;

    localparam int NP = 4, NC = 8, MT = 8, CW = 3;
    localparam int S_IDLE = 0, S_EDIT = 1, S_DONE = 2;

    logic clk = 1'b0, rst_n = 1'b0, secret_load = 1'b0;
    logic btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_s = 1'b0;
    logic [NP*CW-1:0] secret_in = '0;
    logic [1:0]       cur_peg;
    logic [NP*CW-1:0] guess_out;
    logic [2:0]       black, white;
    logic             score_valid, busy, won, lost;
    logic [MT-1:0]    turn_led;

    mastermind_core #(.N_PEGS(NP), .N_COLORS(NC), .MAX_TURNS(MT)) dut (
        .clk(clk), .rst_n(rst_n), .secret_load(secret_load), .secret_in(secret_in),
        .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d), .btn_s(btn_s),
        .cur_peg(cur_peg), .guess_out(guess_out), .black(black), .white(white),
        .score_valid(score_valid), .turn_led(turn_led), .busy(busy), .won(won), .lost(lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0, checks = 0;

    typedef struct {int t; int b; int w; bit won; bit lost; int turn;} exp_t;
    exp_t exp_q[$];

    int m_sec[NP], m_gue[NP];
    int m_cur = 0, m_turn = 0, m_b = 0, m_w = 0, m_state = S_IDLE;
    bit m_won = 0, m_lost = 0;

    task automatic chk(input string n, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (score_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_score_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sv_latency", cyc, e.t);
                chk("sv_black", black, e.b);
                chk("sv_white", white, e.w);
                chk("sv_won", won, e.won);
                chk("sv_lost", lost, e.lost);
                chk("sv_turn_led", turn_led, 1 << e.turn);
                chk("sv_busy", busy, 0);
            end
        end
    end

    function automatic logic [NP*CW-1:0] pk(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic logic [NP*CW-1:0] gpack();
        logic [NP*CW-1:0] g;
        g = '0;
        for (int i = 0; i < NP; i++) g[i*CW +: CW] = 3'(m_gue[i]);
        return g;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_guess"}, guess_out, gpack());
        chk({tag, "_cur_peg"}, cur_peg, m_cur);
        chk({tag, "_turn_led"}, turn_led, (m_state == S_IDLE) ? 0 : (1 << m_turn));
        chk({tag, "_won"}, won, m_won);
        chk({tag, "_lost"}, lost, m_lost);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_black"}, black, m_b);
        chk({tag, "_white"}, white, m_w);
    endtask

    task automatic submit();
        int b, tot, cs, cg;
        exp_t e;
        b = 0;
        tot = 0;
        for (int i = 0; i < NP; i++) if (m_gue[i] == m_sec[i]) b++;
        for (int c = 0; c < NC; c++) begin
            cs = 0;
            cg = 0;
            for (int i = 0; i < NP; i++) begin
                cs += (m_sec[i] == c) ? 1 : 0;
                cg += (m_gue[i] == c) ? 1 : 0;
            end
            tot += (cs < cg) ? cs : cg;
        end
        m_b = b;
        m_w = tot - b;
        if (b == NP) begin
            m_won = 1;
            m_state = S_DONE;
        end else if (m_turn == MT - 1) begin
            m_lost = 1;
            m_state = S_DONE;
        end else begin
            m_turn++;
        end
        e.t = cyc + NC + 1;
        e.b = m_b;
        e.w = m_w;
        e.won = m_won;
        e.lost = m_lost;
        e.turn = m_turn;
        exp_q.push_back(e);
        repeat (NC + 1) begin
            {btn_l, btn_r, btn_u, btn_d, btn_s} = 5'($urandom);
            tick();
        end
        {btn_l, btn_r, btn_u, btn_d, btn_s} = '0;
    endtask

    task automatic press(input bit l, input bit r, input bit u, input bit d, input bit s);
        {btn_l, btn_r, btn_u, btn_d, btn_s} = {l, r, u, d, s};
        tick();
        {btn_l, btn_r, btn_u, btn_d, btn_s} = '0;
        if (m_state == S_EDIT) begin
            if (s) begin
                submit();
            end else begin
                if (u && !d) m_gue[m_cur] = (m_gue[m_cur] + 1) % NC;
                if (d && !u) m_gue[m_cur] = (m_gue[m_cur] + NC - 1) % NC;
                if (l && !r) m_cur = (m_cur + NP - 1) % NP;
                if (r && !l) m_cur = (m_cur + 1) % NP;
            end
        end
        check_state("press");
    endtask

    task automatic load(input logic [NP*CW-1:0] v, input bit noise);
        secret_in = v;
        secret_load = 1'b1;
        if (noise) {btn_l, btn_r, btn_u, btn_d, btn_s} = 5'($urandom);
        tick();
        secret_load = 1'b0;
        {btn_l, btn_r, btn_u, btn_d, btn_s} = '0;
        for (int i = 0; i < NP; i++) begin
            m_sec[i] = int'(v[i*CW +: CW]);
            m_gue[i] = 0;
        end
        m_cur = 0;
        m_turn = 0;
        m_b = 0;
        m_w = 0;
        m_won = 0;
        m_lost = 0;
        m_state = S_EDIT;
        check_state("load");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NP; i++) m_gue[i] = 0;
        m_cur = 0;
        m_turn = 0;
        m_b = 0;
        m_w = 0;
        m_won = 0;
        m_lost = 0;
        m_state = S_IDLE;
        check_state("reset");
        chk("reset_score_valid", score_valid, 0);
    endtask

    task automatic set_guess(input logic [NP*CW-1:0] v);
        for (int p = 0; p < NP; p++) begin
            while (m_cur != p) press(0, 1, 0, 0, 0);
            while (m_gue[p] != int'(v[p*CW +: CW])) press(0, 0, 1, 0, 0);
        end
    endtask

    initial begin
        logic [NP*CW-1:0] sec;
        do_reset();
        press(0, 0, 1, 0, 0);
        press(0, 0, 0, 0, 1);

        load(pk(1, 2, 3, 4), 0);
        press(0, 0, 0, 0, 1);
        chk("t1_black", black, 0);
        chk("t1_white", white, 0);
        chk("t1_turn_led", turn_led, 8'b0000_0010);

        set_guess(pk(4, 3, 2, 1));
        press(0, 0, 0, 0, 1);
        chk("t2a_white", white, 4);
        set_guess(pk(1, 2, 4, 3));
        press(0, 0, 0, 0, 1);
        chk("t2b_black", black, 2);
        chk("t2b_white", white, 2);

        load(pk(1, 1, 2, 2), 1);
        set_guess(pk(1, 2, 1, 1));
        press(0, 0, 0, 0, 1);
        chk("t3_black", black, 1);
        chk("t3_white", white, 2);

        set_guess(pk(1, 1, 2, 2));
        press(0, 0, 0, 0, 1);
        chk("t4_won", won, 1);
        press(0, 0, 1, 0, 0);
        press(0, 0, 0, 0, 1);
        repeat (12) tick();
        check_state("t4_done");
        load(pk(1, 2, 3, 4), 0);
        chk("t4_reload_won", won, 0);

        for (int k = 0; k < MT; k++) begin
            set_guess(pk(0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
            press(0, 0, 0, 0, 1);
        end
        chk("t5_lost", lost, 1);
        chk("t5_turn_led", turn_led, 8'b1000_0000);
        press(0, 0, 0, 0, 1);
        repeat (12) tick();
        check_state("t5_done");

        load(pk(5, 6, 7, 0), 0);
        press(1, 0, 0, 0, 0);
        chk("t6_wrap_left", cur_peg, 3);
        press(0, 0, 0, 1, 0);
        chk("t6_wrap_colour", guess_out[11:9], 7);
        press(0, 0, 1, 1, 0);
        press(1, 1, 1, 0, 0);

        btn_s = 1'b1;
        tick();
        btn_s = 1'b0;
        tick();
        tick();
        load(pk(2, 2, 2, 2), 0);
        repeat (12) tick();
        check_state("t6_abort");
        press(0, 1, 1, 0, 0);

        btn_s = 1'b1;
        tick();
        btn_s = 1'b0;
        repeat (4) tick();
        do_reset();
        repeat (12) tick();
        check_state("t6_reset_idle");

        for (int g = 0; g < 4; g++) begin
            sec = 12'($urandom);
            load(sec, 1);
            while (m_state == S_EDIT) begin
                repeat ($urandom_range(3, 10))
                    press(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
                if ($urandom_range(0, 3) == 0) set_guess(sec);
                press(0, 0, 0, 0, 1);
            end
        end

        repeat (20) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
